// File: rtl/wd_supervisor_pkg.sv
// Shared watchdog definitions: FSM state encodings and default sizing used by
// the supervisor and the timer blocks it drives.
package wd_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_REARM = 2'b10
    } wd_state_e;

    localparam int DEFAULT_MAX_RETRY = 3;
    localparam int DEFAULT_RW        = 2;

endpackage

// File: rtl/wd_supervisor_if.sv
// Handshake bundle between a requester/timer side (master) and the supervisor
// (slave); clk and rst travel as plain ports alongside it.
interface wd_supervisor_if #(
    parameter int RW = 2
);
    logic          start;
    logic          event_in;
    logic          timeout_in;
    logic          count_en;
    logic [RW-1:0] retry_cnt;
    logic          busy;
    logic          done;
    logic          fail;
    logic [1:0]    state;

    modport master (
        output start, event_in, timeout_in,
        input  count_en, retry_cnt, busy, done, fail, state
    );

    modport slave (
        input  start, event_in, timeout_in,
        output count_en, retry_cnt, busy, done, fail, state
    );
endinterface

// File: rtl/wd_retry_counter.sv
// Saturating re-arm counter: cleared when a new wait begins, stepped on each
// timeout that earns a re-arm, never allowed past MAX_RETRY.
module wd_retry_counter #(
    parameter int MAX_RETRY = 3,
    parameter int RW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          incr,
    output logic [RW-1:0] count,
    output logic          at_max
);

    localparam logic [RW-1:0] LIMIT = RW'(MAX_RETRY);

    assign at_max = (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wd_supervisor.sv
// Watchdog supervisor: runs the external 100 ms timer, re-arms it on timeout up
// to MAX_RETRY times, and pulses done on a response or fail once retries run out.
module wd_supervisor
    import wd_supervisor_pkg::*;
#(
    parameter int MAX_RETRY = DEFAULT_MAX_RETRY,
    parameter int RW        = DEFAULT_RW
) (
    input  logic           clk,
    input  logic           rst,
    wd_supervisor_if.slave bus
);

    wd_state_e     state_q;
    logic          count_en_q;
    logic          busy_q;
    logic          done_q;
    logic          fail_q;
    logic [RW-1:0] retry_cnt;
    logic          at_max;
    logic          clear_cnt;
    logic          incr_cnt;

    // An event in the same cycle as a timeout wins, so only a bare timeout consumes a retry.
    assign clear_cnt = (state_q == ST_IDLE) && bus.start;
    assign incr_cnt  = (state_q == ST_WAIT) && bus.timeout_in && !bus.event_in && !at_max;

    wd_retry_counter #(
        .MAX_RETRY (MAX_RETRY),
        .RW        (RW)
    ) u_retry (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_cnt),
        .incr   (incr_cnt),
        .count  (retry_cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_WAIT;
                        count_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.event_in) begin
                        state_q    <= ST_IDLE;
                        count_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (bus.timeout_in) begin
                        count_en_q <= 1'b0;
                        if (at_max) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= ST_REARM;
                        end
                    end
                end
                // One cycle with count_en low is what clears the external timer.
                ST_REARM: begin
                    state_q    <= ST_WAIT;
                    count_en_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    count_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.count_en  = count_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_cnt;

endmodule

// File: tb/tb_wd_supervisor.sv
// Scoreboard bench for wd_supervisor: a default build and a MAX_RETRY=0 build share
// one stimulus stream, each checked against its own behavioural model.
module tb_wd_supervisor;

    typedef struct {
        int count_en;
        int busy;
        int done;
        int fail;
        int retry;
        int state;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s = 1'b0;
    logic event_s = 1'b0;
    logic timeout_s = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    obs_t q0[$];
    obs_t q1[$];

    bit active[2];
    bit rearming[2];
    int retries[2];
    bit done_m[2];
    bit fail_m[2];
    int max_m[2];

    always #5 clk = ~clk;

    wd_supervisor_if #(.RW(2)) if0();
    wd_supervisor_if #(.RW(2)) if1();

    assign if0.start = start_s;
    assign if0.event_in = event_s;
    assign if0.timeout_in = timeout_s;
    assign if1.start = start_s;
    assign if1.event_in = event_s;
    assign if1.timeout_in = timeout_s;

    wd_supervisor #(.MAX_RETRY(3), .RW(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    wd_supervisor #(.MAX_RETRY(0), .RW(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareRec(input string tag, input obs_t act, input obs_t exp);
        checkOutput({tag, ".count_en"}, act.count_en, exp.count_en);
        checkOutput({tag, ".busy"}, act.busy, exp.busy);
        checkOutput({tag, ".done"}, act.done, exp.done);
        checkOutput({tag, ".fail"}, act.fail, exp.fail);
        checkOutput({tag, ".retry_cnt"}, act.retry, exp.retry);
        checkOutput({tag, ".state"}, act.state, exp.state);
    endtask

    // Reference behaviour in terms of "is a wait active", "is the timer being cleared", and a retry tally.
    task automatic modelStep(input int d, output obs_t o);
        done_m[d] = 1'b0;
        fail_m[d] = 1'b0;
        if (rst) begin
            active[d] = 1'b0;
            rearming[d] = 1'b0;
            retries[d] = 0;
        end else if (!active[d]) begin
            if (start_s) begin
                active[d] = 1'b1;
                rearming[d] = 1'b0;
                retries[d] = 0;
            end
        end else if (rearming[d]) begin
            rearming[d] = 1'b0;
        end else if (event_s) begin
            active[d] = 1'b0;
            done_m[d] = 1'b1;
        end else if (timeout_s) begin
            if (retries[d] >= max_m[d]) begin
                active[d] = 1'b0;
                fail_m[d] = 1'b1;
            end else begin
                retries[d] = retries[d] + 1;
                rearming[d] = 1'b1;
            end
        end
        o.count_en = (active[d] && !rearming[d]) ? 1 : 0;
        o.busy = active[d] ? 1 : 0;
        o.done = done_m[d] ? 1 : 0;
        o.fail = fail_m[d] ? 1 : 0;
        o.retry = retries[d];
        o.state = !active[d] ? 0 : (rearming[d] ? 2 : 1);
    endtask

    initial begin
        obs_t e;
        max_m[0] = 3;
        max_m[1] = 0;
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0;
            rearming[d] = 1'b0;
            retries[d] = 0;
        end
        forever begin
            @(posedge clk);
            modelStep(0, e);
            q0.push_back(e);
            modelStep(1, e);
            q1.push_back(e);
        end
    end

    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a.count_en = int'(if0.count_en);
                a.busy = int'(if0.busy);
                a.done = int'(if0.done);
                a.fail = int'(if0.fail);
                a.retry = int'(if0.retry_cnt);
                a.state = int'(if0.state);
                compareRec("max3", a, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a.count_en = int'(if1.count_en);
                a.busy = int'(if1.busy);
                a.done = int'(if1.done);
                a.fail = int'(if1.fail);
                a.retry = int'(if1.retry_cnt);
                a.state = int'(if1.state);
                compareRec("max0", a, e);
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit s, input bit ev, input bit to, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = r;
            start_s = s;
            event_s = ev;
            timeout_s = to;
        end
    endtask

    initial begin
        $display("[TB] wd_supervisor scoreboard run starting");
        applyStimulus(1, 0, 0, 0, 2);

        // Start, response on the fifth waiting cycle.
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 4);
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);

        // No response: four timeouts exhaust the default build.
        applyStimulus(0, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 2);
            applyStimulus(0, 0, 0, 1, 1);
            applyStimulus(0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 2);

        // Event and timeout together.
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 2);

        // Start held high through wait and re-arm.
        applyStimulus(0, 1, 0, 0, 3);
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 2);
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);

        // Reset lands together with a timeout at retry_cnt=2.
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 2);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
                          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 22, 1);
        end

        applyStimulus(0, 0, 0, 0, 3);
        @(negedge clk);
        #1;
        checkOutput("max3.queue_drain", q0.size(), 0);
        checkOutput("max0.queue_drain", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wd_supervisor.md
WD_SUPERVISOR -- requirements
Module: wd_supervisor

Interface
REQ-001 SHALL provide parameter MAX_RETRY, default 3: number of timer re-arms allowed before failure.
REQ-002 SHALL provide parameter RW, default 2: width of retry counter; MAX_RETRY SHALL be <= 2^RW-1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a supervised wait; level sampled each edge.
REQ-006 event_in  input  1  awaited response (heartbeat/keypress), sampled each edge.
REQ-007 timeout_in  input  1  TimeOut from the 100 ms watchdog timer.
REQ-008 count_en  output  1  drives timer Count; high = timer runs, low = timer cleared.
REQ-009 retry_cnt  output  RW  re-arms consumed in current wait.
REQ-010 busy  output  1  high while not IDLE.
REQ-011 done  output  1  one-cycle pulse: event received before final timeout.
REQ-012 fail  output  1  one-cycle pulse: retries exhausted.
REQ-013 state  output  2  current FSM state (debug).

Function
REQ-014 FSM states SHALL be IDLE=00, WAIT=01, REARM=10; code 11 unused, SHALL return to IDLE next edge.
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 IDLE: count_en=0, busy=0; start=1 -> WAIT, retry_cnt cleared to 0.
REQ-017 Start latency: start high at edge k -> count_en=1, busy=1 after edge k.
REQ-018 WAIT: count_en=1; event_in=1 -> done=1 for exactly one cycle, -> IDLE.
REQ-019 WAIT, timeout_in=1, event_in=0, retry_cnt<MAX_RETRY -> retry_cnt+1, -> REARM.
REQ-020 WAIT, timeout_in=1, event_in=0, retry_cnt==MAX_RETRY -> fail=1 for one cycle, -> IDLE; retry_cnt holds final value until next start.
REQ-021 Simultaneous event_in and timeout_in in WAIT: event wins (done, no retry, no fail).
REQ-022 REARM: count_en=0 for exactly one cycle (clears timer), then -> WAIT unconditionally; event_in and timeout_in ignored in REARM.
REQ-023 start while busy SHALL be ignored; no restart, no counter change.
REQ-024 done and fail SHALL never be high in the same cycle; each SHALL be low in all other cycles.
REQ-025 retry_cnt SHALL never exceed MAX_RETRY; no wrap-around.
REQ-026 MAX_RETRY=0: first timeout in WAIT gives fail directly, REARM never entered.
REQ-027 event_in or timeout_in in IDLE SHALL have no effect.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, count_en=0, retry_cnt=0, busy=0, done=0, fail=0, regardless of state.
REQ-029 rst SHALL dominate start, event_in, timeout_in in the same cycle; reset mid-WAIT SHALL drop count_en the following cycle and suppress any pending done/fail.

Structure
REQ-030 State encodings (IDLE/WAIT/REARM) SHALL be defined as constants in the shared watchdog package used by the timer blocks.
REQ-031 Retry counter SHALL be a sub-module wd_retry_counter (clear, increment, saturate at MAX_RETRY, clk/rst ports).
REQ-032 Block SHALL connect directly to the 100 ms watchdog timer: count_en -> Count, TimeOut -> timeout_in.

Verification
REQ-033 Reset then start pulse; event_in at 5th cycle of WAIT -> count_en high from cycle after start, done=1 one cycle, state=00, retry_cnt=0.
REQ-034 Start, no event, MAX_RETRY=3: four timeouts -> three REARM cycles with count_en=0, retry_cnt 1,2,3, then fail=1 once, busy=0.
REQ-035 event_in and timeout_in asserted same cycle in WAIT -> done=1, fail=0, retry_cnt unchanged.
REQ-036 start re-asserted during WAIT and REARM -> ignored; retry_cnt and state sequence unchanged.
REQ-037 rst asserted in WAIT with retry_cnt=2 and timeout_in=1 same cycle -> next cycle all outputs zero, no fail pulse.
REQ-038 MAX_RETRY=0 build: start, one timeout -> fail=1 next cycle, state never 10.
